ascii_scroll_buffer: RTL and testbench
======================================

// Module: ascii_scroll_buffer
// PURPOSE
//  Upstream feeder for the per-digit ASCII-to-7-segment decoders. Stores a message loaded one byte
//  at a time, then scrolls it right-to-left across NUM_DIGITS displays at a fixed tick rate.
//  DigitAscii byte i drives decoder instance i (i=0 rightmost). Replaces static message selection.
// PARAMETERS
//  NUM_DIGITS  5           number of 7-seg digits driven
//  MSG_DEPTH   16          message buffer capacity in bytes (>=1)
//  TICK_DIV    25_000_000  clocks per scroll step (>=1; 1 = step every cycle)
// PORTS
//  Clk         in   1             single clock, all state on rising edge
//  ResetN      in   1             synchronous, active-low reset
//  WrValid     in   1             message byte valid
//  WrData      in   8             ASCII byte
//  WrLast      in   1             qualifies WrData as the final byte of the message
//  WrReady     out  1             buffer accepts a byte this cycle
//  Run         in   1             1 = scroll, 0 = freeze display and prescaler
//  Clear       in   1             discard message, blank display, return to IDLE
//  DigitAscii  out  8*NUM_DIGITS  [8*i+:8] = ASCII for digit i; registered
//  MsgLen      out  $clog2(MSG_DEPTH+1)  committed/accumulated length L
//  Scrolling   out  1             state == SCROLL
// BEHAVIOUR
//  Reset (ResetN=0 at edge): state IDLE, every DigitAscii byte 8'h20, MsgLen 0, rp 0, prescaler 0,
//   Scrolling 0. Applies identically mid-load or mid-scroll. 8'h20 decodes to all segments off.
//  States: IDLE -> LOAD on first accepted byte; LOAD -> SCROLL on commit; any -> IDLE on Clear.
//  WrReady = 1 in IDLE and LOAD, 0 in SCROLL. Byte accepted when WrValid && WrReady:
//   buf[MsgLen] <= WrData, MsgLen <= MsgLen+1.
//  Commit: accepted byte with WrLast=1, or accepted byte that makes MsgLen==MSG_DEPTH (implicit).
//   The commit edge sets state SCROLL, rp 0, prescaler 0; display remains blank. L >= 1 always.
//  Prescaler: counts only in SCROLL with Run=1; at TICK_DIV-1 it wraps to 0 and a step occurs.
//   Run=0 holds both prescaler value and display, with no steps.
//  Step: DigitAscii shifts one digit left (digit NUM_DIGITS-1 dropped). Digit 0 <= rp<L ? buf[rp] : 8'h20.
//   rp <= (rp==P-1) ? 0 : rp+1, with period P = L + GAP.
//  First character appears on digit 0 at the first step, TICK_DIV cycles after commit.
//  Clear: highest priority below reset. Next edge: IDLE, display all 8'h20, MsgLen 0, rp 0.
//   A write in the same cycle is dropped.
//  L < NUM_DIGITS with GAP=0: the message repeats back-to-back across the display (no error).
// CONFIGURATION
//  `define ASCII_SCROLL_GAP_EN: GAP = NUM_DIGITS; a full screen of blanks separates repetitions.
//  Not defined: GAP = 0; the message wraps directly (last char then first char).
// STRUCTURE
//  Package ascii_disp_pkg: ASCII_SPACE = 8'h20, scroll_state_t enum {IDLE, LOAD, SCROLL}.
//  Sub-module scroll_tick_gen: TICK_DIV prescaler with enable and sync clear, emits 1-cycle step pulse.
//  Buffer is a flat register array (MSG_DEPTH x 8); no RAM inference required.
// TESTING (NUM_DIGITS=5, MSG_DEPTH=16, TICK_DIV=2)
//  Reset: DigitAscii == {5{8'h20}}, WrReady=1, Scrolling=0, MsgLen=0.
//  Load "Hello" (WrLast on 'o'), Run=1. After 5 steps: digits 4..0 = "Hello".
//   Step 6 gives "elloH" (gap off) / "ello " (gap on).
//  Run=0 after 3 steps for 20 cycles: DigitAscii constant ("  Hel"). Run=1 resumes; step 4 gives " Hell".
//  16 bytes with no WrLast: after the 16th accept, Scrolling=1, WrReady=0, MsgLen=16.
//   A 17th WrValid is not accepted.
//  Clear during SCROLL, with a simultaneous write: next cycle display all 8'h20, WrReady=1,
//   MsgLen=0, byte not stored.
//  ResetN=0 for one edge mid-LOAD after 3 bytes: MsgLen=0, state IDLE; a fresh load "AB" scrolls correctly.

Source files
------------

// File: rtl/ascii_disp_pkg.sv
// ascii_disp_pkg: shared constants and state type for the ASCII scroll buffer
package ascii_disp_pkg;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} scroll_state_t;
endpackage

// File: rtl/ascii_scroll_buffer_if.sv
// ascii_scroll_buffer_if: message write port, scroll control and display outputs
interface ascii_scroll_buffer_if #(
  parameter int NUM_DIGITS = 5,
  parameter int MSG_DEPTH  = 16
);
  localparam int LW = $clog2(MSG_DEPTH + 1);
  logic                    WrValid;
  logic [7:0]              WrData;
  logic                    WrLast;
  logic                    WrReady;
  logic                    Run;
  logic                    Clear;
  logic [8*NUM_DIGITS-1:0] DigitAscii;
  logic [LW-1:0]           MsgLen;
  logic                    Scrolling;
  modport master (output WrValid, WrData, WrLast, Run, Clear,
                  input WrReady, DigitAscii, MsgLen, Scrolling);
  modport slave  (input WrValid, WrData, WrLast, Run, Clear,
                  output WrReady, DigitAscii, MsgLen, Scrolling);
endinterface

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: TICK_DIV prescaler with enable and sync clear, one-cycle step pulse
module scroll_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign step = en && cnt == CW'(TICK_DIV - 1);
  // count while enabled, wrapping on the step cycle; hold otherwise
  always_ff @(posedge Clk)
    if (!ResetN || clr) cnt <= '0;
    else if (en) cnt <= step ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ascii_scroll_buffer.sv
// ascii_scroll_buffer: loads a message byte-wise and scrolls it right-to-left; ASCII_SCROLL_GAP_EN adds a blank screen between repeats
module ascii_scroll_buffer
  import ascii_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 5,
  parameter int MSG_DEPTH  = 16,
  parameter int TICK_DIV   = 25_000_000
) (
  input logic            Clk,
  input logic            ResetN,
  ascii_scroll_buffer_if.slave bus
);
`ifdef ASCII_SCROLL_GAP_EN
  localparam int GAP = NUM_DIGITS;
`else
  localparam int GAP = 0;
`endif
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int IW = MSG_DEPTH > 1 ? $clog2(MSG_DEPTH) : 1;
  localparam int RW = $clog2(MSG_DEPTH + GAP + 1);
  scroll_state_t state, nxt;
  logic [7:0]    mem [MSG_DEPTH];
  logic [RW-1:0] rp, p_last;
  logic          accept, commit, step;
  logic [7:0]    ch;
  assign bus.WrReady   = state != SCROLL;
  assign bus.Scrolling = state == SCROLL;
  assign accept = bus.WrValid && bus.WrReady && !bus.Clear;
  assign commit = accept && (bus.WrLast || bus.MsgLen == LW'(MSG_DEPTH - 1));
  assign p_last = RW'(bus.MsgLen) + RW'(GAP) - 1'b1;
  assign ch     = rp < RW'(bus.MsgLen) ? mem[rp[IW-1:0]] : ASCII_SPACE;
  scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk    (Clk),
    .ResetN (ResetN),
    .en     (bus.Run && state == SCROLL && !bus.Clear),
    .clr    (state != SCROLL || bus.Clear),
    .step   (step)
  );
  // state register
  always_ff @(posedge Clk)
    state <= !ResetN ? IDLE : nxt;
  // next state: Clear wins, then commit, then first accepted byte
  always_comb begin
    nxt = state;
    nxt = bus.Clear ? IDLE : commit ? SCROLL : accept ? LOAD : state;
  end
  // message storage; contents are don't-care until written
  always_ff @(posedge Clk)
    if (accept) mem[bus.MsgLen[IW-1:0]] <= bus.WrData;
  // length, read pointer and display shift register
  always_ff @(posedge Clk)
    if (!ResetN || bus.Clear) begin
      bus.MsgLen     <= '0;
      rp             <= '0;
      bus.DigitAscii <= {NUM_DIGITS{ASCII_SPACE}};
    end else begin
      if (accept) bus.MsgLen <= bus.MsgLen + 1'b1;
      if (commit) rp <= '0;
      else if (step) begin
        bus.DigitAscii <= (bus.DigitAscii << 8) | (8*NUM_DIGITS)'(ch);
        rp             <= rp == p_last ? '0 : rp + 1'b1;
      end
    end
endmodule

// File: tb/tb_ascii_scroll_buffer.sv
// tb_ascii_scroll_buffer: directed checks of load, scroll, freeze, overflow, clear and reset
module tb_ascii_scroll_buffer;
  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  ascii_scroll_buffer_if #(.NUM_DIGITS(5), .MSG_DEPTH(16)) bus ();
  ascii_scroll_buffer #(.NUM_DIGITS(5), .MSG_DEPTH(16), .TICK_DIV(2)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last);
    bus.WrValid = 1'b1;
    bus.WrData  = d;
    bus.WrLast  = last;
    tick(1);
    bus.WrValid = 1'b0;
    bus.WrLast  = 1'b0;
  endtask

  task automatic clear();
    bus.Clear = 1'b1;
    tick(1);
    bus.Clear = 1'b0;
  endtask

  task automatic load_hello();
    wr("H", 0); wr("e", 0); wr("l", 0); wr("l", 0); wr("o", 1);
  endtask

  initial begin
    logic [39:0] snap;
    bus.WrValid = 0; bus.WrData = 0; bus.WrLast = 0; bus.Run = 0; bus.Clear = 0;
    tick(2);
    ResetN = 1'b1;
    check("rst_digits", bus.DigitAscii, {5{8'h20}});
    check("rst_ready", bus.WrReady, 1);
    check("rst_scroll", bus.Scrolling, 0);
    check("rst_len", bus.MsgLen, 0);

    bus.Run = 1'b1;
    load_hello();
    check("hello_len", bus.MsgLen, 5);
    check("hello_scroll", bus.Scrolling, 1);
    check("hello_blank", bus.DigitAscii, {5{8'h20}});
    tick(1);
    check("first_step_not_early", bus.DigitAscii, {5{8'h20}});
    tick(1);
    check("first_step", bus.DigitAscii, {32'h20202020, "H"});
    tick(8);
    check("hello_5", bus.DigitAscii, "Hello");
    tick(2);
`ifdef ASCII_SCROLL_GAP_EN
    check("hello_6", bus.DigitAscii, "ello ");
`else
    check("hello_6", bus.DigitAscii, "elloH");
`endif

    clear();
    load_hello();
    tick(6);
    check("freeze_pre", bus.DigitAscii, "  Hel");
    bus.Run = 1'b0;
    snap = bus.DigitAscii;
    tick(20);
    check("freeze_hold", bus.DigitAscii, "  Hel");
    bus.Run = 1'b1;
    tick(1);
    check("resume_no_early", bus.DigitAscii, "  Hel");
    tick(1);
    check("resume_step4", bus.DigitAscii, " Hell");

    bus.Run = 1'b0;
    clear();
    check("clr_scroll", bus.Scrolling, 0);
    for (int i = 0; i < 16; i++) wr(8'h41 + 8'(i), 0);
    check("full_scroll", bus.Scrolling, 1);
    check("full_ready", bus.WrReady, 0);
    check("full_len", bus.MsgLen, 16);
    wr("Z", 0);
    check("full_17th", bus.MsgLen, 16);
    bus.Run = 1'b1;
    tick(2);
    check("full_first", bus.DigitAscii, {32'h20202020, "A"});

    bus.WrValid = 1'b1; bus.WrData = "Q"; bus.Clear = 1'b1;
    tick(1);
    bus.WrValid = 1'b0; bus.Clear = 1'b0;
    check("clr_digits", bus.DigitAscii, {5{8'h20}});
    check("clr_ready", bus.WrReady, 1);
    check("clr_len", bus.MsgLen, 0);
    bus.WrValid = 1'b1; bus.WrData = "Q"; bus.Clear = 1'b1;
    tick(1);
    bus.WrValid = 1'b0; bus.Clear = 1'b0;
    check("clr_idle_write", bus.MsgLen, 0);
    check("clr_idle_state", bus.Scrolling, 0);

    wr("x", 0); wr("y", 0); wr("z", 0);
    check("mid_len", bus.MsgLen, 3);
    ResetN = 1'b0;
    tick(1);
    ResetN = 1'b1;
    check("mid_rst_len", bus.MsgLen, 0);
    check("mid_rst_scroll", bus.Scrolling, 0);
    check("mid_rst_ready", bus.WrReady, 1);
    wr("A", 0); wr("B", 1);
    check("ab_len", bus.MsgLen, 2);
    tick(4);
    check("ab_2", bus.DigitAscii, {24'h202020, "AB"});
    tick(2);
`ifdef ASCII_SCROLL_GAP_EN
    check("ab_3", bus.DigitAscii, {16'h2020, "AB", 8'h20});
`else
    check("ab_3", bus.DigitAscii, {16'h2020, "ABA"});
`endif
    check("snap_used", {24'h0, snap}, {24'h0, "  Hel"});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
